// File: rtl/signed_18x18_pipelined_multiplier.sv
// Signed 18x18 -> 36-bit multiplier, three pipeline stages, single computation in flight.
// Split into 9-bit halves so each partial product maps onto a small multiplier.
module signed_18x18_pipelined_multiplier (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [17:0] a,
  input  logic signed [17:0] b,
  input  logic               input_rdy,
  output logic signed [35:0] p,
  output logic               busy
);

  logic signed [17:0] opa;
  logic signed [17:0] opb;
  logic               active;
  logic               valid;
  logic               v1;
  logic               v2;
  logic               v3;
  logic               mismatch;
  logic               launch;

  logic signed [17:0] pp_hh;
  logic signed [18:0] pp_hl;
  logic signed [18:0] pp_lh;
  logic        [17:0] pp_ll;
  logic signed [35:0] sum_r;

  logic signed [8:0]  ah;
  logic signed [8:0]  bh;
  logic signed [9:0]  al_s;
  logic signed [9:0]  bl_s;
  logic signed [17:0] hh_c;
  logic signed [18:0] hl_c;
  logic signed [18:0] lh_c;
  logic        [17:0] ll_c;
  logic signed [35:0] sum_c;

  // Handshake: the client holds input_rdy and may change a/b at any time; busy
  // rises combinationally in that same cycle, and p == a*b whenever busy is low.
  assign mismatch = (a != opa) || (b != opb);
  assign busy     = input_rdy & (active | ~valid | mismatch);
  assign launch   = input_rdy & ~active & (~valid | mismatch);

  // High halves are signed, low halves are unsigned magnitudes.
  assign ah   = opa[17:9];
  assign bh   = opb[17:9];
  assign al_s = $signed({1'b0, opa[8:0]});
  assign bl_s = $signed({1'b0, opb[8:0]});

  assign hh_c = $signed({{9{ah[8]}}, ah}) * $signed({{9{bh[8]}}, bh});
  assign hl_c = $signed({{10{ah[8]}}, ah}) * $signed({{9{bl_s[9]}}, bl_s});
  assign lh_c = $signed({{9{al_s[9]}}, al_s}) * $signed({{10{bh[8]}}, bh});
  assign ll_c = {9'b0, opa[8:0]} * {9'b0, opb[8:0]};

  assign sum_c = $signed({pp_hh, 18'b0})
               + $signed({{8{pp_hl[18]}}, pp_hl, 9'b0})
               + $signed({{8{pp_lh[18]}}, pp_lh, 9'b0})
               + $signed({18'b0, pp_ll});

  always_ff @(posedge clk) begin
    if (reset) begin
      opa    <= '0;
      opb    <= '0;
      active <= 1'b0;
      valid  <= 1'b0;
      v1     <= 1'b0;
      v2     <= 1'b0;
      v3     <= 1'b0;
      pp_hh  <= '0;
      pp_hl  <= '0;
      pp_lh  <= '0;
      pp_ll  <= '0;
      sum_r  <= '0;
      p      <= '0;
    end else begin
      v1 <= launch;
      v2 <= v1;
      v3 <= v2;
      if (launch) begin
        opa    <= a;
        opb    <= b;
        active <= 1'b1;
        valid  <= 1'b0;
      end
      if (v1) begin
        pp_hh <= hh_c;
        pp_hl <= hl_c;
        pp_lh <= lh_c;
        pp_ll <= ll_c;
      end
      if (v2) sum_r <= sum_c;
      // Completion cannot coincide with a launch: launch requires !active.
      if (v3) begin
        p      <= sum_r;
        active <= 1'b0;
        valid  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_signed_18x18_pipelined_multiplier.sv
// Directed bench for the pipelined signed multiplier: latency, boundaries,
// mid-flight operand change, input_rdy gating and mid-operation reset.
module tb_signed_18x18_pipelined_multiplier;

  logic               clk;
  logic               reset;
  logic signed [17:0] a;
  logic signed [17:0] b;
  logic               input_rdy;
  logic signed [35:0] p;
  logic               busy;

  int errors = 0;
  int checks = 0;

  signed_18x18_pipelined_multiplier dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .input_rdy (input_rdy),
    .p         (p),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [35:0] observed, input logic [35:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(observed), $signed(expected));
    end
  endtask

  task automatic check_busy(input string tag, input logic expected);
    checks++;
    assert (busy === expected)
    else begin
      errors++;
      $error("FAIL %s busy observed=%b expected=%b", tag, busy, expected);
    end
  endtask

  // Apply operands right after an edge, confirm busy rises at once, then after
  // exactly four edges the product must be present with busy low.
  task automatic run_vec(input string tag, input logic signed [17:0] va,
                         input logic signed [17:0] vb, input longint expected);
    a = va;
    b = vb;
    #1;
    check_busy({tag, "_busy_now"}, 1'b1);
    cyc(3);
    check_busy({tag, "_busy_t3"}, 1'b1);
    cyc(1);
    check_busy({tag, "_busy_done"}, 1'b0);
    check({tag, "_p"}, p, 36'(expected));
  endtask

  initial begin
    reset     = 1'b1;
    input_rdy = 1'b0;
    a         = '0;
    b         = '0;
    cyc(2);
    reset = 1'b0;
    #1;
    check("reset_p", p, 36'd0);
    check_busy("reset_idle", 1'b0);

    // Basic latency and hold
    input_rdy = 1'b1;
    run_vec("v3x4", 18'sd3, 18'sd4, 64'sd12);
    cyc(3);
    check("v3x4_hold_p", p, 36'd12);
    check_busy("v3x4_hold", 1'b0);

    // Extremes
    run_vec("minxmin", -18'sd131072, -18'sd131072, 64'sd17179869184);
    run_vec("maxxmin", 18'sd131071, -18'sd131072, -64'sd17179738112);
    run_vec("maxxmax", 18'sd131071, 18'sd131071, 64'sd17179607041);
    run_vec("m1xm1", -18'sd1, -18'sd1, 64'sd1);
    run_vec("lowhalf", 18'sd511, 18'sd512, 64'sd261632);
    run_vec("m512xm1", -18'sd512, -18'sd1, 64'sd512);
    run_vec("mixed", 18'sd12345, -18'sd6789, -64'sd83810205);

    // Back-to-back: change b on the cycle busy falls
    run_vec("b2b_a", 18'sd100, -18'sd5, -64'sd500);
    run_vec("b2b_b", 18'sd100, 18'sd7, 64'sd700);

    // Operand change one cycle after launch
    a = 18'sd10;
    b = 18'sd3;
    cyc(1);
    a = 18'sd20;
    #1;
    check_busy("midchg_busy", 1'b1);
    cyc(3);
    check("midchg_first_p", p, 36'd30);
    check_busy("midchg_first_busy", 1'b1);
    cyc(3);
    check_busy("midchg_relaunch_busy", 1'b1);
    cyc(1);
    check("midchg_final_p", p, 36'd60);
    check_busy("midchg_final_busy", 1'b0);

    // input_rdy low gates launches
    input_rdy = 1'b0;
    a = 18'sd7;
    b = 18'sd9;
    #1;
    check_busy("rdy_low_busy", 1'b0);
    cyc(5);
    check("rdy_low_p", p, 36'd60);
    check_busy("rdy_low_busy_later", 1'b0);
    input_rdy = 1'b1;
    run_vec("rdy_raise", 18'sd7, 18'sd9, 64'sd63);

    // Reset mid-computation
    a = -18'sd2;
    b = 18'sd1000;
    cyc(2);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    #1;
    check("midrst_p", p, 36'd0);
    check_busy("midrst_busy", 1'b1);
    cyc(3);
    check_busy("midrst_busy_t3", 1'b1);
    cyc(1);
    check("midrst_recomp_p", p, -36'sd2000);
    check_busy("midrst_recomp_busy", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
